// File: rtl/hamm_secded_codec_if.sv
// ============================================================================
// Module   : hamm_secded_codec_if
// Brief    : Stream, status and counter bundle for the SECDED codec.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hamm_secded_codec_if #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16
);
  localparam int CODE_W = DATA_W + PAR_W + 1;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [CODE_W-1:0] in_word;
  logic              out_valid;
  logic              out_ready;
  logic [CODE_W-1:0] out_word;
  logic              out_sec;
  logic              out_ded;
  logic [PAR_W-1:0]  out_syndrome;
  logic              clr_cnt;
  logic [CNT_W-1:0]  cnt_sec;
  logic [CNT_W-1:0]  cnt_ded;

  modport master (
    output in_valid, in_mode, in_word, out_ready, clr_cnt,
    input  in_ready, out_valid, out_word, out_sec, out_ded, out_syndrome,
           cnt_sec, cnt_ded
  );

  modport slave (
    input  in_valid, in_mode, in_word, out_ready, clr_cnt,
    output in_ready, out_valid, out_word, out_sec, out_ded, out_syndrome,
           cnt_sec, cnt_ded
  );
endinterface

`default_nettype wire

// File: rtl/hamm_secded_codec.sv
// ============================================================================
// Module   : hamm_secded_codec
// Brief    : Two-stage streaming Hamming SECDED encoder/decoder with counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamm_secded_codec #(
  parameter int DATA_W = 8,
  parameter int PAR_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  hamm_secded_codec_if.slave     bus
);
  localparam int               CODE_W    = DATA_W + PAR_W + 1;
  localparam int               C_MAX_POS = DATA_W + PAR_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  function automatic logic f_is_pow2(input int pos);
    return (pos & (pos - 1)) == 0;
  endfunction

  function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    logic              p;
    int                di;
    cw = '0;
    di = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (!f_is_pow2(pos)) begin
        cw[pos] = data[di];
        di++;
      end
    end
    // Parity slots are still zero here, so each group XOR sees only data.
    for (int k = 0; k < PAR_W; k++) begin
      p = 1'b0;
      for (int pos = 1; pos < CODE_W; pos++) begin
        if (((pos >> k) & 1) != 0) p = p ^ cw[pos];
      end
      if ((1 << k) < CODE_W) cw[1 << k] = p;
    end
    cw[0] = ^cw;
    return cw;
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] data;
    int                di;
    data = '0;
    di   = 0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (!f_is_pow2(pos)) begin
        data[di] = cw[pos];
        di++;
      end
    end
    return data;
  endfunction

  function automatic logic [PAR_W-1:0] f_syndrome(input logic [CODE_W-1:0] cw);
    logic [PAR_W-1:0] s;
    s = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (cw[pos]) s = s ^ PAR_W'(pos);
    end
    return s;
  endfunction

  logic              r_s1_valid;
  logic              r_s1_mode;
  logic              r_s1_par;
  logic [CODE_W-1:0] r_s1_word;
  logic [PAR_W-1:0]  r_s1_syn;

  logic              r_out_valid;
  logic [CODE_W-1:0] r_out_word;
  logic              r_out_sec;
  logic              r_out_ded;
  logic [PAR_W-1:0]  r_out_syn;
  logic [CNT_W-1:0]  r_cnt_sec;
  logic [CNT_W-1:0]  r_cnt_ded;

  logic              w_en;
  logic              w_out_hs;
  logic [CODE_W-1:0] w_fixed;
  logic [CODE_W-1:0] w_next_word;
  logic              w_sec;
  logic              w_ded;

  assign w_en     = !r_out_valid || bus.out_ready;
  assign w_out_hs = r_out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_par   <= 1'b0;
      r_s1_word  <= '0;
      r_s1_syn   <= '0;
    end else if (w_en) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1_mode <= bus.in_mode;
        r_s1_word <= bus.in_word;
        r_s1_syn  <= bus.in_mode ? f_syndrome(bus.in_word) : '0;
        r_s1_par  <= bus.in_mode ? ^bus.in_word : 1'b0;
      end
    end
  end

  always_comb begin
    w_fixed     = r_s1_word;
    w_sec       = 1'b0;
    w_ded       = 1'b0;
    w_next_word = '0;
    if (r_s1_mode) begin
      if (r_s1_par) begin
        if (r_s1_syn == '0) begin
          w_sec = 1'b1;
        end else if (int'(r_s1_syn) <= C_MAX_POS) begin
          w_sec = 1'b1;
          for (int pos = 1; pos < CODE_W; pos++) begin
            if (int'(r_s1_syn) == pos) w_fixed[pos] = ~r_s1_word[pos];
          end
        end else begin
          w_ded = 1'b1;
        end
      end else if (r_s1_syn != '0) begin
        w_ded = 1'b1;
      end
      w_next_word = {{(CODE_W-DATA_W){1'b0}}, f_extract(w_fixed)};
    end else begin
      w_next_word = f_encode(r_s1_word[DATA_W-1:0]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_valid <= 1'b0;
      r_out_word  <= '0;
      r_out_sec   <= 1'b0;
      r_out_ded   <= 1'b0;
      r_out_syn   <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s1_valid;
      r_out_word  <= w_next_word;
      r_out_sec   <= w_sec;
      r_out_ded   <= w_ded;
      r_out_syn   <= r_s1_mode ? r_s1_syn : '0;
    end
  end

  // Clear wins over a same-cycle handshake; that beat's count is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt_sec <= '0;
      r_cnt_ded <= '0;
    end else if (bus.clr_cnt) begin
      r_cnt_sec <= '0;
      r_cnt_ded <= '0;
    end else if (w_out_hs) begin
      if (r_out_sec && (r_cnt_sec != C_CNT_MAX)) r_cnt_sec <= r_cnt_sec + 1'b1;
      if (r_out_ded && (r_cnt_ded != C_CNT_MAX)) r_cnt_ded <= r_cnt_ded + 1'b1;
    end
  end

  assign bus.in_ready     = w_en;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_word     = r_out_word;
  assign bus.out_sec      = r_out_sec;
  assign bus.out_ded      = r_out_ded;
  assign bus.out_syndrome = r_out_syn;
  assign bus.cnt_sec      = r_cnt_sec;
  assign bus.cnt_ded      = r_cnt_ded;

endmodule

`default_nettype wire

// File: tb/tb_hamm_secded_codec.sv
// Self-checking bench for hamm_secded_codec (DATA_W=8, PAR_W=4, CNT_W=2).
`default_nettype none

module tb_hamm_secded_codec;
  localparam int DATA_W  = 8;
  localparam int PAR_W   = 4;
  localparam int CNT_W   = 2;
  localparam int CODE_W  = 13;
  localparam int CNT_MAX = 3;

  typedef struct packed {
    logic [CODE_W-1:0] word;
    logic              sec;
    logic              ded;
    logic [PAR_W-1:0]  syn;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   m_sec  = 0;
  int   m_ded  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  hamm_secded_codec_if #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) bus ();

  hamm_secded_codec #(.DATA_W(DATA_W), .PAR_W(PAR_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic exp_t mk(input logic [CODE_W-1:0] w, input logic s, input logic d,
                              input logic [PAR_W-1:0] syn);
    exp_t e;
    e.word = w; e.sec = s; e.ded = d; e.syn = syn;
    return e;
  endfunction

  // Reference model: explicit data-position table for the 8-bit layout.
  function automatic exp_t model(input logic mode, input logic [CODE_W-1:0] w);
    int                dpos [0:7];
    exp_t              e;
    logic [CODE_W-1:0] cw;
    logic              p;
    int                s;
    dpos = '{3, 5, 6, 7, 9, 10, 11, 12};
    e = '0;
    if (!mode) begin
      cw = '0;
      for (int i = 0; i < 8; i++) cw[dpos[i]] = w[i];
      for (int k = 0; k < 4; k++) begin
        p = 1'b0;
        for (int pos = 1; pos < CODE_W; pos++) if ((pos & (1 << k)) != 0) p = p ^ cw[pos];
        cw[1 << k] = p;
      end
      cw[0] = ^cw;
      e.word = cw;
    end else begin
      s = 0;
      for (int pos = 1; pos < CODE_W; pos++) if (w[pos]) s = s ^ pos;
      p  = ^w;
      cw = w;
      if (p) begin
        if (s == 0) e.sec = 1'b1;
        else if (s <= 12) begin cw[s] = ~cw[s]; e.sec = 1'b1; end
        else e.ded = 1'b1;
      end else if (s != 0) e.ded = 1'b1;
      for (int i = 0; i < 8; i++) e.word[i] = cw[dpos[i]];
      e.syn = 4'(s);
    end
    return e;
  endfunction

  // Scoreboard: pop on each output handshake and track expected counters.
  always @(negedge clk) begin : mon
    exp_t e;
    logic got;
    got = 1'b0;
    e   = '0;
    if (reset === 1'b1) begin
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL out_beat unexpected word=%h while none outstanding", bus.out_word);
        end else begin
          e   = q.pop_front();
          got = 1'b1;
          if ({bus.out_word, bus.out_sec, bus.out_ded, bus.out_syndrome} !== e) begin
            errors++;
            $display("FAIL out_beat got word=%h sec=%b ded=%b syn=%0d required word=%h sec=%b ded=%b syn=%0d",
                     bus.out_word, bus.out_sec, bus.out_ded, bus.out_syndrome,
                     e.word, e.sec, e.ded, e.syn);
          end
        end
      end
      if (bus.clr_cnt) begin
        m_sec = 0;
        m_ded = 0;
      end else if (got) begin
        if (e.sec && m_sec < CNT_MAX) m_sec++;
        if (e.ded && m_ded < CNT_MAX) m_ded++;
      end
    end
  end

  task automatic send(input logic mode, input logic [CODE_W-1:0] w, input exp_t e);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_word  = w;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.in_ready) begin
      errors++;
      $display("FAIL send_accept in_ready=%b required=1", bus.in_ready);
    end else begin
      q.push_back(e);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain outstanding=%0d required=0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.out_valid, bus.cnt_sec, bus.cnt_ded} !== 5'b0) begin
      errors++;
      $display("FAIL reset_state valid=%b cnt_sec=%0d cnt_ded=%0d required 0/0/0",
               bus.out_valid, bus.cnt_sec, bus.cnt_ded);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got=%b required=1", bus.in_ready);
    end
  endtask

  task automatic test_encode();
    bus.out_ready = 1'b1;
    send(1'b0, 13'h1FA5, mk(13'h144E, 1'b0, 1'b0, 4'd0));
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_latency_early out_valid=%b required=0", bus.out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_word !== 13'h144E) begin
      errors++;
      $display("FAIL enc_latency valid=%b word=%h required valid=1 word=144e",
               bus.out_valid, bus.out_word);
    end
    drain();
  endtask

  task automatic test_decode_sec();
    send(1'b1, 13'h144E, mk(13'h00A5, 1'b0, 1'b0, 4'd0));
    send(1'b1, 13'h140E, mk(13'h00A5, 1'b1, 1'b0, 4'd6));
    send(1'b1, 13'h144F, mk(13'h00A5, 1'b1, 1'b0, 4'd0));
    drain();
    checks++;
    if (int'(bus.cnt_sec) != m_sec || m_sec != 2) begin
      errors++;
      $display("FAIL dec_cnt_sec got=%0d required=2", bus.cnt_sec);
    end
  endtask

  task automatic test_decode_ded();
    send(1'b1, 13'h100E, mk(model(1'b1, 13'h100E).word, 1'b0, 1'b1, 4'd12));
    send(1'b1, 13'h155C, mk(model(1'b1, 13'h155C).word, 1'b0, 1'b1, 4'd13));
    drain();
    checks++;
    if (int'(bus.cnt_ded) != m_ded || m_ded != 2) begin
      errors++;
      $display("FAIL dec_cnt_ded got=%0d required=2", bus.cnt_ded);
    end
  endtask

  task automatic test_backpressure();
    logic [CODE_W+PAR_W+1:0] prev;
    logic                    prev_stall;
    prev       = '0;
    prev_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          logic              m;
          logic [CODE_W-1:0] w;
          m = i[0];
          if (m) w = model(1'b0, 13'($urandom)).word ^ (13'd1 << $urandom_range(0, 12));
          else   w = 13'($urandom);
          send(m, w, model(m, w));
        end
      end
      begin
        for (int c = 0; c < 30; c++) begin
          @(posedge clk); #1;
          bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        end
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (prev_stall) begin
            checks++;
            if (!bus.out_valid ||
                {bus.out_word, bus.out_sec, bus.out_ded, bus.out_syndrome} !== prev) begin
              errors++;
              $display("FAIL stall_hold valid=%b word=%h required valid=1 word=%h",
                       bus.out_valid, bus.out_word, prev[CODE_W+PAR_W+1:PAR_W+2]);
            end
          end
          if (bus.out_valid && !bus.out_ready) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
              errors++;
              $display("FAIL stall_in_ready got=%b required=0", bus.in_ready);
            end
            prev_stall = 1'b1;
            prev       = {bus.out_word, bus.out_sec, bus.out_ded, bus.out_syndrome};
          end else begin
            prev_stall = 1'b0;
          end
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();
  endtask

  task automatic test_counters();
    bus.clr_cnt = 1'b1;
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    checks++;
    if (bus.cnt_sec !== 2'd0 || bus.cnt_ded !== 2'd0) begin
      errors++;
      $display("FAIL cnt_clear sec=%0d ded=%0d required 0/0", bus.cnt_sec, bus.cnt_ded);
    end
    repeat (4) send(1'b1, 13'h140E, mk(13'h00A5, 1'b1, 1'b0, 4'd6));
    drain();
    checks++;
    if (bus.cnt_sec !== 2'd3 || m_sec != CNT_MAX) begin
      errors++;
      $display("FAIL cnt_saturate got=%0d required=3", bus.cnt_sec);
    end
    send(1'b1, 13'h144F, mk(13'h00A5, 1'b1, 1'b0, 4'd0));
    @(posedge clk); #1;
    bus.clr_cnt = 1'b1;
    checks++;
    if (!(bus.out_valid && bus.out_sec)) begin
      errors++;
      $display("FAIL clr_align valid=%b sec=%b required 1/1", bus.out_valid, bus.out_sec);
    end
    @(posedge clk); #1;
    bus.clr_cnt = 1'b0;
    checks++;
    if (bus.cnt_sec !== 2'd0) begin
      errors++;
      $display("FAIL clr_priority cnt_sec=%0d required=0", bus.cnt_sec);
    end
    drain();
  endtask

  task automatic test_reset_midstream();
    send(1'b1, 13'h140E, mk(13'h00A5, 1'b1, 1'b0, 4'd6));
    send(1'b1, 13'h100E, model(1'b1, 13'h100E));
    drain();
    checks++;
    if (bus.cnt_sec !== 2'd1 || bus.cnt_ded !== 2'd1) begin
      errors++;
      $display("FAIL pre_reset_cnt sec=%0d ded=%0d required 1/1", bus.cnt_sec, bus.cnt_ded);
    end
    bus.out_ready = 1'b0;
    send(1'b0, 13'h003C, model(1'b0, 13'h003C));
    send(1'b1, 13'h144E, model(1'b1, 13'h144E));
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL pipe_full valid=%b in_ready=%b required 1/0", bus.out_valid, bus.in_ready);
    end
    #3;
    reset = 1'b0;
    q.delete();
    m_sec = 0;
    m_ded = 0;
    #1;
    checks++;
    if ({bus.out_valid, bus.cnt_sec, bus.cnt_ded} !== 5'b0) begin
      errors++;
      $display("FAIL async_reset valid=%b cnt_sec=%0d cnt_ded=%0d required 0/0/0",
               bus.out_valid, bus.cnt_sec, bus.cnt_ded);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    send(1'b0, 13'h005A, model(1'b0, 13'h005A));
    drain();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_stray out_valid=%b required=0", bus.out_valid);
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b1;
    bus.clr_cnt   = 1'b0;
    test_reset();
    test_encode();
    test_decode_sec();
    test_decode_ded();
    test_backpressure();
    test_counters();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/hamm_secded_codec.md
Name: hamm_secded_codec

Overview:
Parametrised streaming Hamming SECDED codec. It succeeds the fixed 4-bit hamm_encoder/hamm_decoder pair.
- Each accepted beat selects encode or decode.
- Two-stage pipeline with valid/ready backpressure.
- Saturating error counters for link-health monitoring.
- Sits between the data source and the channel model on the transmit side, and between the channel and the sink on the receive side.

Parameters:
- DATA_W, 8, data bits per word (4..57).
- PAR_W, 4, Hamming parity bits; must satisfy 2^PAR_W >= DATA_W+PAR_W+1.
- CNT_W, 16, width of each error counter.
- CODE_W (localparam), DATA_W+PAR_W+1, codeword width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- in_mode  in  1  0 = encode, 1 = decode; sampled with the beat.
- in_word  in  CODE_W  encode: data in [DATA_W-1:0], upper bits ignored; decode: received codeword.
- out_valid  out  1  output beat valid.
- out_ready  in  1  sink accepts the beat.
- out_word  out  CODE_W  encode: codeword; decode: corrected data in [DATA_W-1:0], upper bits 0.
- out_sec  out  1  decode beat had a single error and it was corrected.
- out_ded  out  1  decode beat is uncorrectable.
- out_syndrome  out  PAR_W  Hamming syndrome of the decode beat; 0 in encode mode.
- clr_cnt  in  1  synchronous clear of both counters.
- cnt_sec  out  CNT_W  number of corrected beats delivered.
- cnt_ded  out  CNT_W  number of uncorrectable beats delivered.

Behaviour:
- Codeword layout:
  - Bit 0 is the overall parity, chosen so the full word has even parity.
  - Bits 1..DATA_W+PAR_W are Hamming positions.
  - Power-of-two positions hold parity bits.
  - Remaining positions hold data bits d0.. in ascending order.
  - Parity bit 2^k = XOR of all data positions whose index has bit k set.
- Reset (reset=0, asynchronous) clears:
  - out_valid, stage-1 valid, out_word, out_sec, out_ded, out_syndrome, cnt_sec, cnt_ded.
  - A beat in flight when reset asserts is discarded; no partial output.
- Pipeline:
  - Advance enable en = !out_valid || out_ready; in_ready = en. This is a combinational path from out_ready to in_ready.
  - Stage 1 registers mode and word on in_valid && en.
  - In decode mode, stage 1 also computes the syndrome S (XOR of indices of set positions) and the overall parity p (XOR of all CODE_W bits).
  - Stage 2 (output register) loads from stage 1 when en. out_valid follows the stage-1 valid.
  - Latency is 2 cycles from input handshake to out_valid when out_ready is held high. Full throughput of one beat per cycle.
  - While out_valid && !out_ready, all outputs hold stable and no beat is accepted or dropped.
- Decode classification:
  - S=0, p=0: clean; sec=0, ded=0.
  - p=1, S=0: error in bit 0; sec=1, data unchanged.
  - p=1, 1 <= S <= DATA_W+PAR_W: flip position S, then extract data; sec=1.
  - p=1, S > DATA_W+PAR_W: ded=1; data extracted uncorrected.
  - p=0, S != 0: ded=1; data extracted uncorrected.
  - sec and ded are never both 1.
- Encode mode: out_sec=0, out_ded=0, out_syndrome=0.
- Counters:
  - Update only on an output handshake (out_valid && out_ready).
  - cnt_sec increments on out_sec; cnt_ded increments on out_ded.
  - Both saturate at 2^CNT_W-1.
  - clr_cnt has priority: the count for a handshake in the same cycle is lost.
- Mode may change on every beat; there is no pipeline flush.

Test Plan:
DATA_W=8, PAR_W=4, CODE_W=13.
1. Encode 0xA5 with out_ready=1 -> out_word=0x144E two cycles after the handshake; sec=0, ded=0, syndrome=0.
2. Decode the following words:
   - 0x144E -> data 0xA5, sec=0, ded=0, syndrome=0.
   - 0x140E (bit 6 flipped) -> 0xA5, sec=1, syndrome=6.
   - 0x144F (bit 0 flipped) -> 0xA5, sec=1, syndrome=0.
3. Decode 0x100E (bits 6 and 10 flipped) -> ded=1, sec=0, syndrome=12, cnt_ded +1.
   Decode 0x155C (bits 1, 4, 8 flipped) -> ded=1, syndrome=13.
4. Backpressure:
   - Stream 5 alternating encode/decode beats while toggling out_ready 1,0,0,1,...
   - Required: no loss or duplication, outputs stable while stalled, in_ready low when out_valid && !out_ready.
5. Counters with CNT_W=2:
   - Four sec beats -> cnt_sec saturates at 3.
   - clr_cnt in the same cycle as a sec handshake -> cnt_sec=0 next cycle.
6. Reset mid-stream:
   - Drop reset low asynchronously with both stages full.
   - Required: out_valid=0 immediately and counters=0; after release the first output is the first beat accepted after reset.
